// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one SPI master among NUM_REQ requesters, round-robin by default.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module spi_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_CS     = 1,
  parameter int DATA_WIDTH = 8,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int IW  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tx_data,
  input  logic [NUM_REQ*CSW-1:0]        req_slave_id,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          busy,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic [CSW-1:0]                m_slave_id,
  input  logic                          m_ready,
  input  logic [DATA_WIDTH-1:0]         m_rx_data
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt, r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt, r_tx, w_tx_nxt;
  logic [CSW-1:0]        r_sid, w_sid_nxt;
  logic                  r_start, w_start_nxt, r_busy;
  logic [IW-1:0]         r_owner, w_owner_nxt, w_win;
  logic                  w_found;

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_found = 1'b1;
        w_win   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_idx;
  logic          w_retire;

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_REQ)) w_idx = w_idx - (IW+1)'(NUM_REQ);
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  assign w_retire = (r_state == WAIT_DONE) && (r_done == '0) && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= '0;
    else if (w_retire) r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_rx_nxt    = r_rx;
    w_tx_nxt    = r_tx;
    w_sid_nxt   = r_sid;
    w_start_nxt = r_start;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (m_ready && w_found) begin
          w_owner_nxt = w_win;
          w_gnt_nxt   = NUM_REQ'(1) << w_win;
          w_tx_nxt    = req_tx_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
          w_sid_nxt   = req_slave_id[int'(w_win)*CSW +: CSW];
          w_start_nxt = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!m_ready) begin
          w_start_nxt = 1'b0;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_BUSY: begin
        w_start_nxt = 1'b0;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Stay one extra cycle after done so a requester can drop req before re-arbitration.
        if (r_done != '0) begin
          w_gnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (m_ready) begin
          w_rx_nxt   = m_rx_data;
          w_done_nxt = NUM_REQ'(1) << r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_sid   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_rx    <= w_rx_nxt;
      r_tx    <= w_tx_nxt;
      r_sid   <= w_sid_nxt;
      r_start <= w_start_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_owner <= w_owner_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign rx_data    = r_rx;
  assign busy       = r_busy;
  assign m_start    = r_start;
  assign m_tx_data  = r_tx;
  assign m_slave_id = r_sid;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed table-driven bench for spi_arbiter with a loopback master model.
module tb_spi_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_tx_data;
  logic [7:0]  req_slave_id;
  logic [3:0]  gnt, done;
  logic [7:0]  rx_data, m_tx_data, m_rx_data;
  logic        busy, m_start, m_ready;
  logic [1:0]  m_slave_id;

  spi_arbiter #(.NUM_REQ(4), .NUM_CS(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_tx_data(req_tx_data),
    .req_slave_id(req_slave_id), .gnt(gnt), .done(done), .rx_data(rx_data),
    .busy(busy), .m_start(m_start), .m_tx_data(m_tx_data), .m_slave_id(m_slave_id),
    .m_ready(m_ready), .m_rx_data(m_rx_data)
  );

  always #5 clk = ~clk;

  // Loopback master: accepts m_start, stays busy a few cycles, returns the transmitted word.
  logic       mdl_busy, force_low;
  logic [2:0] mdl_cnt;
  logic [7:0] mdl_shift;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0; mdl_cnt <= '0; mdl_shift <= '0; m_rx_data <= '0;
    end else if (!mdl_busy) begin
      if (m_start) begin mdl_busy <= 1'b1; mdl_cnt <= 3'd4; mdl_shift <= m_tx_data; end
    end else if (mdl_cnt == 3'd0) begin
      mdl_busy <= 1'b0; m_rx_data <= mdl_shift;
    end else begin
      mdl_cnt <= mdl_cnt - 3'd1;
    end
  end
  assign m_ready = !mdl_busy && !force_low;

  int viol = 0;
  int done_pulses = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((gnt & (gnt - 4'd1)) != 4'd0) viol++;
      if ((done & ~gnt) != 4'd0) viol++;
      if (done != 4'd0) done_pulses++;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [7:0] tx_nom [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 4; i++) begin
      req_tx_data[i*8 +: 8]  = tx_nom[i];
      req_slave_id[i*2 +: 2] = 2'(i);
    end
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge after the done cycle.
  task automatic run_xfer(input logic [3:0] r, input int idx, input bit drop);
    logic [7:0] etx;
    bit got, stable;
    etx = tx_nom[idx];
    req = r;
    @(negedge clk);
    check("start_lat", 32'(m_start), 1);
    check("gnt", 32'(gnt), 32'(1) << idx);
    check("busy", 32'(busy), 1);
    check("m_tx", 32'(m_tx_data), 32'(etx));
    check("m_sid", 32'(m_slave_id), 32'(idx));
    req_tx_data  = ~req_tx_data;
    req_slave_id = ~req_slave_id;
    got = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 1 && drop) req = r & ~(4'(1) << idx);
      if (done != 4'd0) begin got = 1'b1; break; end
      if (m_tx_data !== etx || m_slave_id !== 2'(idx)) stable = 1'b0;
      @(negedge clk);
    end
    check("done_seen", 32'(got), 1);
    check("done", 32'(done), 32'(1) << idx);
    check("rx", 32'(rx_data), 32'(etx));
    check("tx_stable", 32'(stable), 1);
    set_nominal();
    @(negedge clk);
    check("done_1cyc", 32'(done), 0);
    check("gnt_clr", 32'(gnt), 0);
    check("rx_hold", 32'(rx_data), 32'(etx));
    check("no_early_start", 32'(m_start), 0);
  endtask

  typedef struct {
    logic [3:0] req;
    int         idx_rr;
    int         idx_fp;
    bit         drop;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int idx;
    bit bad, got;
    int pulses0;
    tbl[0] = '{4'b1111, 0, 0, 1'b0};
    tbl[1] = '{4'b1111, 1, 0, 1'b0};
    tbl[2] = '{4'b1111, 2, 0, 1'b0};
    tbl[3] = '{4'b1111, 3, 0, 1'b0};
    tbl[4] = '{4'b1111, 0, 0, 1'b0};
    tbl[5] = '{4'b0010, 1, 1, 1'b0};
    tbl[6] = '{4'b0100, 2, 2, 1'b1};
    tbl[7] = '{4'b0011, 0, 0, 1'b0};
    tbl[8] = '{4'b1001, 3, 0, 1'b0};
    tbl[9] = '{4'b1000, 3, 3, 1'b0};
    tx_nom[0] = 8'h5A; tx_nom[1] = 8'hA5; tx_nom[2] = 8'h3C; tx_nom[3] = 8'hC3;
    rst_n = 1'b0;
    req = 4'b0000;
    force_low = 1'b0;
    set_nominal();

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rx", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(m_start), 0);
    check("rst_mtx", 32'(m_tx_data), 0);
    check("rst_msid", 32'(m_slave_id), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 10; v++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
      idx = tbl[v].idx_fp;
`else
      idx = tbl[v].idx_rr;
`endif
      run_xfer(tbl[v].req, idx, tbl[v].drop);
    end

    // Master not ready in IDLE: nothing issued until it returns.
    force_low = 1'b1;
    req = 4'b0001;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (m_start || gnt != 4'd0) bad = 1'b1;
    end
    check("mready_low_hold", 32'(bad), 0);
    force_low = 1'b0;
    run_xfer(4'b0001, 0, 1'b0);

    // Request withdrawn before it could be granted.
    force_low = 1'b1;
    req = 4'b0010;
    repeat (2) @(negedge clk);
    req = 4'b0000;
    force_low = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_start || gnt != 4'd0 || busy) bad = 1'b1;
    end
    check("drop_before_gnt", 32'(bad), 0);

    // Reset in WAIT_DONE.
    req = 4'b0100;
    @(negedge clk);
    check("rst_t_gnt", 32'(gnt), 32'h4);
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy && !m_start) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_t_wait", 32'(got), 1);
    @(negedge clk);
    pulses0 = done_pulses;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 0);
    check("arst_done", 32'(done), 0);
    check("arst_rx", 32'(rx_data), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_start", 32'(m_start), 0);
    check("arst_mtx", 32'(m_tx_data), 0);
    check("arst_msid", 32'(m_slave_id), 0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_pulses), 32'(pulses0));
    run_xfer(4'b0100, 2, 1'b0);

    check("onehot", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SPI_master, valid range 2..16.
REQ-002 Parameter NUM_CS, default 1: slave-select count of the attached master; CSW = max(1, $clog2(NUM_CS)).
REQ-003 Parameter DATA_WIDTH, default 8: transfer width, equal to the attached master's DATA_WIDTH.
REQ-004 clk  in  1  system clock, shared with the SPI master.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester level request; held until that requester's done pulse.
REQ-007 req_tx_data  in  NUM_REQ*DATA_WIDTH  packed transmit words, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_slave_id  in  NUM_REQ*CSW  packed slave ids, requester i at slice [i*CSW +: CSW].
REQ-009 gnt  out  NUM_REQ  one-hot grant, zero when no transfer is owned.
REQ-010 done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 rx_data  out  DATA_WIDTH  received word, valid in the done cycle and held until the next done.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 m_start  out  1  start strobe to the master.
REQ-014 m_tx_data  out  DATA_WIDTH  transmit word to the master.
REQ-015 m_slave_id  out  CSW  slave select index to the master.
REQ-016 m_ready  in  1  master ready: high when idle, low during a transfer.
REQ-017 m_rx_data  in  DATA_WIDTH  master received word, valid when m_ready rises.

Function
REQ-018 The arbiter SHALL implement four states: IDLE, START, WAIT_BUSY and WAIT_DONE, with all outputs registered.
REQ-019 IDLE: when m_ready=1 and |req, the arbiter SHALL select a winner, latch that winner's data and slave id into m_tx_data/m_slave_id, set gnt, set m_start=1, and go to START on the same edge.
REQ-020 IDLE with m_ready=0 SHALL issue nothing and SHALL remain in IDLE.
REQ-021 START: m_start SHALL stay high until m_ready is sampled low; it SHALL then clear m_start and go to WAIT_DONE (WAIT_BUSY is entered only if the implementation registers the edge separately).
REQ-022 WAIT_DONE: when m_ready is sampled high, the arbiter SHALL register m_rx_data into rx_data, pulse done[owner] for one cycle, clear gnt on the following edge, update the priority pointer, and return to IDLE.
REQ-023 Round-robin: the pointer SHALL reset to 0; the search SHALL start at the pointer and wrap modulo NUM_REQ; after granting requester i, the pointer SHALL become (i+1) mod NUM_REQ.
REQ-024 The latched m_tx_data and m_slave_id SHALL stay stable from grant until done, independent of changes on the requester inputs.
REQ-025 A requester that drops req after being granted SHALL still complete its transfer and receive done.
REQ-026 A requester that drops req before being granted SHALL NOT be served.
REQ-027 A req still high in the cycle after its done pulse SHALL be treated as a new request.
REQ-028 Requests arriving during a transfer SHALL be arbitrated only on return to IDLE.
REQ-029 Latency: m_start SHALL rise 1 cycle after req is sampled in IDLE; the next m_start SHALL come no earlier than 2 cycles after a done pulse.
REQ-030 gnt SHALL be one-hot or zero at all times, and done SHALL pulse only on the bit where gnt is high.

Reset
REQ-031 On rst_n low, the arbiter SHALL immediately enter IDLE with pointer=0, gnt=0, done=0, rx_data=0, busy=0, m_start=0, m_tx_data=0 and m_slave_id=0.
REQ-032 Reset mid-transfer SHALL abandon ownership with no done pulse; the master is reset by the same rst_n.

Configuration
REQ-033 Macro SPI_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with the lowest index winning, and the pointer SHALL be removed; when undefined, arbitration SHALL be round-robin per REQ-023.

Verification
REQ-034 NUM_REQ=4, req=4'b0010, tx=8'hA5, slave_id=0, loopback miso -> m_start rises 1 cycle later with m_tx_data=8'hA5; single done[1] pulse with rx_data=8'hA5.
REQ-035 req=4'b1111 held continuously (round-robin) -> grants in order 0,1,2,3,0; exactly one done per grant.
REQ-036 Same stimulus with SPI_ARB_FIXED_PRIO_EN defined -> grant 0 on every transfer.
REQ-037 req[2] dropped one cycle after gnt[2] rises, tx=8'h3C -> transfer completes and done[2] pulses with rx_data=8'h3C.
REQ-038 rst_n pulsed low during WAIT_DONE -> all outputs at reset values within the same cycle; no done pulse; next req=4'b0100 is served normally.
REQ-039 m_ready forced low in IDLE with req=4'b0001 -> m_start stays 0 and gnt stays 0 until m_ready returns high.
